// File: rtl/shift_pkg.sv
// Shared types for the pipelined barrel shifter.
// Optional macro SHIFT_UNIT_FLAGS_EN adds the out-of-range bit that travels
// down the pipe next to the result.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SRL = 2'b00,
        SHIFT_SLL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_e;

    // Control half of the stage payload. The data word and the remaining
    // amount bits depend on WIDTH, so they travel beside this struct as
    // parametrised vectors.
    typedef struct packed {
        logic      valid;
        shift_op_e op;
        logic      sign;
`ifdef SHIFT_UNIT_FLAGS_EN
        logic      oor;
`endif
    } shift_ctrl_t;

endpackage

// File: rtl/shift_stage.sv
// One barrel stage: conditional shift by 2^K followed by the enable-gated
// pipeline register. Stage K inspects amount bit K only.
module shift_stage
    import shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int K     = 0,
    localparam int LOG2W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] data_in,
    input  logic [LOG2W-1:0] amt_in,
    input  shift_ctrl_t      ctrl_in,
    output logic [WIDTH-1:0] shifted,
    output logic [WIDTH-1:0] data_out,
    output logic [LOG2W-1:0] amt_out,
    output shift_ctrl_t      ctrl_out
);

    localparam int S = 1 << K;

    // Shift by 2^K when this stage's amount bit is set; fill depends on mode
    always_comb begin
        shifted = data_in;
        if (amt_in[K]) begin
            case (ctrl_in.op)
                SHIFT_SRL: shifted = data_in >> S;
                SHIFT_SLL: shifted = data_in << S;
                SHIFT_SRA: shifted = {{S{ctrl_in.sign}}, data_in[WIDTH-1:S]};
                SHIFT_ROR: shifted = {data_in[S-1:0], data_in[WIDTH-1:S]};
                default:   shifted = data_in;
            endcase
        end
    end

    // Stage register: cleared by reset, otherwise loads only on pipeline advance
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            amt_out  <= '0;
            ctrl_out <= '0;
        end else if (en) begin
            data_out <= shifted;
            amt_out  <= amt_in;
            ctrl_out <= ctrl_in;
        end
    end

endmodule

// File: rtl/shift_unit_pipelined.sv
// Pipelined barrel shifter (SRL, SLL, SRA, ROR) with one register per log2
// stage and valid/ready on both sides; one op per cycle without backpressure.
// Optional macro SHIFT_UNIT_FLAGS_EN adds the registered Z_ZERO and Z_OOR
// outputs.
module shift_unit_pipelined
    import shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int LOG2W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [1:0]       OP,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Z
`ifdef SHIFT_UNIT_FLAGS_EN
    ,
    output logic             Z_ZERO,
    output logic             Z_OOR
`endif
);

    logic             adv;
    shift_op_e        op_in;
    logic             oor;
    logic [WIDTH-1:0] acc_data;
    logic [LOG2W-1:0] acc_amt;
    shift_ctrl_t      acc_ctrl;

    logic [LOG2W-1:0][WIDTH-1:0] data_q;
    logic [LOG2W-1:0][WIDTH-1:0] stage_next;
    logic [LOG2W-1:0][LOG2W-1:0] amt_q;
    shift_ctrl_t [LOG2W-1:0]     ctrl_q;
    logic                        unused_tail;

    // The whole pipe moves together; it may move whenever the output slot is
    // empty or being drained, so bubbles are carried rather than collapsed.
    assign op_in     = shift_op_e'(OP);
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;
    assign out_valid = ctrl_q[LOG2W-1].valid;
    assign Z         = data_q[LOG2W-1];

    // Range decision: any set bit above the amount field (including the sign) is out of range, except for rotates
    always_comb begin
        oor = 1'b0;
        if (op_in != SHIFT_ROR) begin
            oor = |Y[WIDTH-1:LOG2W];
        end
    end

    // Stage-0 payload; out-of-range ops enter pre-resolved with a zero amount so the stages pass them through
    always_comb begin
        acc_data       = X;
        acc_amt        = Y[LOG2W-1:0];
        acc_ctrl       = '0;
        acc_ctrl.valid = in_valid;
        acc_ctrl.op    = op_in;
        acc_ctrl.sign  = X[WIDTH-1];
`ifdef SHIFT_UNIT_FLAGS_EN
        acc_ctrl.oor   = oor;
`endif
        if (oor) begin
            acc_amt  = '0;
            acc_data = (op_in == SHIFT_SRA) ? {WIDTH{X[WIDTH-1]}} : '0;
        end
    end

    for (genvar k = 0; k < LOG2W; k++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        logic [LOG2W-1:0] a_in;
        shift_ctrl_t      c_in;

        if (k == 0) begin : g_head
            assign d_in = acc_data;
            assign a_in = acc_amt;
            assign c_in = acc_ctrl;
        end else begin : g_link
            assign d_in = data_q[k-1];
            assign a_in = amt_q[k-1];
            assign c_in = ctrl_q[k-1];
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .K     (k)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .en       (adv),
            .data_in  (d_in),
            .amt_in   (a_in),
            .ctrl_in  (c_in),
            .shifted  (stage_next[k]),
            .data_out (data_q[k]),
            .amt_out  (amt_q[k]),
            .ctrl_out (ctrl_q[k])
        );
    end

`ifdef SHIFT_UNIT_FLAGS_EN
    logic z_zero_q;

    // Zero flag is registered from the final stage's next value so it loads, holds and resets with Z
    always_ff @(posedge clk) begin
        if (rst) begin
            z_zero_q <= 1'b0;
        end else if (adv) begin
            z_zero_q <= (stage_next[LOG2W-1] == '0);
        end
    end

    assign Z_ZERO = z_zero_q;
    assign Z_OOR  = ctrl_q[LOG2W-1].oor;
`endif

    // Tail fields that only matter inside the pipe (last amount, op, sign and
    // the combinational stage outputs) are folded here on purpose.
    assign unused_tail = ^{stage_next, amt_q[LOG2W-1], ctrl_q[LOG2W-1].op,
                           ctrl_q[LOG2W-1].sign};

endmodule

// File: tb/tb_shift_unit_pipelined.sv
// Self-checking bench for shift_unit_pipelined at WIDTH=32.
// Define SHIFT_UNIT_FLAGS_EN to also check Z_ZERO and Z_OOR.
module tb_shift_unit_pipelined;

    localparam int WIDTH = 32;
    localparam int LOG2W = 5;
    localparam int NDIR  = 18;

    typedef struct {
        logic        valid;
        logic        known;
        logic [31:0] z;
        logic        oor;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] X = '0;
    logic [31:0] Y = '0;
    logic [1:0]  OP = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] Z;
`ifdef SHIFT_UNIT_FLAGS_EN
    logic        Z_ZERO;
    logic        Z_OOR;
`endif

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   checking = 1'b0;
    bit   rand_on = 1'b0;
    slot_t pipe [LOG2W];
    int   xfer_cycles [$];

    logic [31:0] dir_x  [NDIR] = '{32'h80000001, 32'h80000001, 32'h80000001, 32'h80000001,
                                   32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'h00000008,
                                   32'hA5A51234, 32'hA5A51234, 32'hA5A51234, 32'hA5A51234,
                                   32'h0, 32'h0, 32'h0, 32'h0,
                                   32'h80000000, 32'h12345678};
    logic [31:0] dir_y  [NDIR] = '{32'd1, 32'd1, 32'd1, 32'd1,
                                   32'hFFFFFFFF, 32'hFFFFFFFF, 32'd32, 32'd35,
                                   32'd0, 32'd0, 32'd0, 32'd0,
                                   32'd0, 32'd0, 32'd0, 32'd0,
                                   32'd31, 32'hFFFFFFFD};
    logic [1:0]  dir_op [NDIR] = '{2'b00, 2'b10, 2'b01, 2'b11,
                                   2'b00, 2'b10, 2'b01, 2'b11,
                                   2'b00, 2'b01, 2'b10, 2'b11,
                                   2'b00, 2'b01, 2'b10, 2'b11,
                                   2'b10, 2'b11};
    logic [31:0] dir_z  [NDIR] = '{32'h40000000, 32'hC0000000, 32'h00000002, 32'hC0000000,
                                   32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000001,
                                   32'hA5A51234, 32'hA5A51234, 32'hA5A51234, 32'hA5A51234,
                                   32'h0, 32'h0, 32'h0, 32'h0,
                                   32'hFFFFFFFF, 32'h91A2B3C0};
    logic        dir_oor [NDIR] = '{1'b0, 1'b0, 1'b0, 1'b0,
                                    1'b1, 1'b1, 1'b1, 1'b0,
                                    1'b0, 1'b0, 1'b0, 1'b0,
                                    1'b0, 1'b0, 1'b0, 1'b0,
                                    1'b0, 1'b0};

    always #5 clk = ~clk;

    shift_unit_pipelined #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .OP        (OP),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Z         (Z)
`ifdef SHIFT_UNIT_FLAGS_EN
        ,
        .Z_ZERO    (Z_ZERO),
        .Z_OOR     (Z_OOR)
`endif
    );

    // Reference rules: out of range means negative or >= 32, rotates never are
    function automatic logic ref_oor(input logic [31:0] y, input logic [1:0] op);
        return (op != 2'b11) && (($signed(y) < 0) || (y >= 32));
    endfunction

    function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [31:0] y,
                                              input logic [1:0] op);
        logic [31:0] r;
        int          amt;
        if (op == 2'b11) begin
            amt = int'(y % 32);
            if (amt == 0) return x;
            return (x >> amt) | (x << (32 - amt));
        end
        if (ref_oor(y, op)) return (op == 2'b10) ? {32{x[31]}} : 32'h0;
        case (op)
            2'b00:   r = x >> y;
            2'b01:   r = x << y;
            default: r = $signed(x) >>> y;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rand_amount();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 31));
            1:       return 32'($urandom_range(0, 70));
            2:       return 32'($urandom);
            default: return 32'h0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkFlag(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present one operand set and hold it until an edge where in_ready is high
    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic [1:0] op);
        int guard = 0;
        X = x;
        Y = y;
        OP = op;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            tests++;
            fails++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitResult(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    // Behavioural model: an LOG2W-deep delay line of transactions that advances with the global enable
    always @(posedge clk) begin
        slot_t s;
        cyc <= cyc + 1;
        if (rst) begin
            for (int i = 0; i < LOG2W; i++) pipe[i] <= '{1'b0, 1'b1, 32'h0, 1'b0};
        end else if (out_ready || !pipe[LOG2W-1].valid) begin
            s.valid = in_valid;
            s.known = in_valid;
            s.z     = in_valid ? ref_shift(X, Y, OP) : 32'h0;
            s.oor   = in_valid ? ref_oor(Y, OP) : 1'b0;
            for (int i = LOG2W - 1; i > 0; i--) pipe[i] <= pipe[i-1];
            pipe[0] <= s;
        end
    end

    // Compare process: every cycle, DUT outputs against the model's output slot
    always @(negedge clk) begin
        if (checking) begin
            checkFlag("out_valid", out_valid, pipe[LOG2W-1].valid);
            checkFlag("in_ready", in_ready, out_ready || !pipe[LOG2W-1].valid);
            if (pipe[LOG2W-1].known) begin
                checkOutput("Z", Z, pipe[LOG2W-1].z);
`ifdef SHIFT_UNIT_FLAGS_EN
                checkFlag("Z_OOR", Z_OOR, pipe[LOG2W-1].oor);
                checkFlag("Z_ZERO", Z_ZERO, pipe[LOG2W-1].valid && (pipe[LOG2W-1].z == 32'h0));
`endif
            end
            if (out_valid && out_ready) xfer_cycles.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat;
        int          base;
        logic [31:0] z_held;

        // Reset and its visible state
        @(posedge clk);
        #1;
        checking = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkFlag("reset_valid", out_valid, 1'b0);
        checkOutput("reset_z", Z, 32'h0);
        checkFlag("reset_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Directed values, latency and range cases
        for (int i = 0; i < NDIR; i++) begin
            checkOutput("model_pin", ref_shift(dir_x[i], dir_y[i], dir_op[i]), dir_z[i]);
            applyStimulus(dir_x[i], dir_y[i], dir_op[i]);
            waitResult(lat);
            checkOutput("latency", 32'(lat), 32'd5);
            checkOutput("dir_z", Z, dir_z[i]);
`ifdef SHIFT_UNIT_FLAGS_EN
            checkFlag("dir_oor", Z_OOR, dir_oor[i]);
            checkFlag("dir_zero", Z_ZERO, dir_z[i] == 32'h0);
`endif
            @(posedge clk);
            #1;
        end

        // Throughput: 8 back-to-back ops, results on consecutive cycles from cycle 5
        xfer_cycles.delete();
        base = cyc;
        for (int i = 0; i < 8; i++) applyStimulus($urandom, rand_amount(), 2'($urandom_range(0, 3)));
        repeat (12) @(negedge clk);
        checkOutput("tp_count", 32'(xfer_cycles.size()), 32'd8);
        if (xfer_cycles.size() == 8) begin
            checkOutput("tp_first", 32'(xfer_cycles[0] - base), 32'd5);
            checkOutput("tp_last", 32'(xfer_cycles[7] - base), 32'd12);
        end
        @(posedge clk);
        #1;

        // Backpressure: four stalled cycles mid-stream
        xfer_cycles.delete();
        fork
            begin
                for (int i = 0; i < 8; i++) applyStimulus($urandom, rand_amount(), 2'($urandom_range(0, 3)));
            end
            begin
                repeat (7) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                z_held = pipe[LOG2W-1].z;
                checkFlag("bp_valid", out_valid, 1'b1);
                checkFlag("bp_ready", in_ready, 1'b0);
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("bp_hold_z", Z, z_held);
                    checkFlag("bp_ready", in_ready, 1'b0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (15) @(negedge clk);
        checkOutput("bp_count", 32'(xfer_cycles.size()), 32'd8);
        @(posedge clk);
        #1;

        // Reset with three ops in flight
        for (int i = 0; i < 3; i++) applyStimulus($urandom, rand_amount(), 2'($urandom_range(0, 3)));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        xfer_cycles.delete();
        @(negedge clk);
        checkFlag("rst_valid", out_valid, 1'b0);
        checkOutput("rst_z", Z, 32'h0);
        checkFlag("rst_ready", in_ready, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("rst_stale", 32'(xfer_cycles.size()), 32'd0);
        @(posedge clk);
        #1;

        // Random traffic with random gaps and random backpressure
        rand_on = 1'b1;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    applyStimulus($urandom, rand_amount(), 2'($urandom_range(0, 3)));
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
